ps2_cmd_ctrl: RTL
=================

Name: ps2_cmd_ctrl

Overview:
- Command sequencer sitting in front of the PS/2 host transmitter and beside the PS/2 receiver.
- After reset it runs a fixed device init sequence: reset, then enable data reporting.
- Once init completes, it accepts single-byte host commands over valid/ready and pulses the transmitter.
- It checks the device response (0xFA ACK / 0xFE RESEND), retries and times out, and forwards unsolicited device bytes as a stream.

Parameters:
ACK_TIMEOUT_CYC, 1_000_000, cycles to wait for tx completion or ACK (20 ms at 50 MHz)
BAT_TIMEOUT_CYC, 25_000_000, cycles to wait for each post-reset byte (0xAA, then ID)
MAX_RETRY, 3, resend attempts before declaring error

Ports:
clk_sys  in  1  50 MHz system clock
rst_n  in  1  async active-low reset
tx_wr_en  out  1  one-cycle write strobe to transmitter
tx_wr_data  out  8  byte to transmit, valid with tx_wr_en
tx_wr_done  in  1  one-cycle pulse, transmitter finished
rx_vld  in  1  one-cycle pulse, received byte valid
rx_data  in  8  received byte
cmd_vld  in  1  host command valid
cmd_data  in  8  host command byte
cmd_rdy  out  1  controller can accept a command
rsp_vld  out  1  one-cycle pulse, host command finished
rsp_ok  out  1  qualifies rsp_vld: 1 = ACKed, 0 = failed
pkt_vld  out  1  one-cycle pulse, unsolicited device byte
pkt_data  out  8  unsolicited device byte
init_done  out  1  high while in READY or a command state
err  out  1  sticky error flag, cleared only by rst_n
err_code  out  2  0 none, 1 timeout, 2 bad response, 3 retries exhausted

Behaviour:
- Reset values: all outputs 0. State is INIT_SEND. Counters are 0. The byte register holds 0xFF.
- Clocking: one clock domain, clk_sys. Reset is asynchronous and active-low, on rst_n.
- Reset mid-operation: returns to INIT_SEND. The transmitter shares rst_n, so no stale handshake survives.
- Send/wait pattern: in every *_SEND state, tx_wr_en=1 and tx_wr_data=byte for exactly one cycle, then the FSM goes to the matching *_WAIT_DONE state.
- Timer: *_WAIT_DONE leaves on tx_wr_done. The timer clears on every state change.
- Timeout in *_WAIT_DONE: exceeding ACK_TIMEOUT_CYC sets err, err_code=1 and enters ERROR.
- Init sequence:
  - INIT_SEND/INIT_WAIT_DONE with 0xFF, then INIT_WAIT_ACK.
  - INIT_WAIT_ACK: 0xFA goes to INIT_WAIT_BAT.
  - INIT_WAIT_BAT: 0xAA goes to INIT_WAIT_ID.
  - INIT_WAIT_ID: any byte goes to INIT_EN_SEND with 0xF4, then WAIT_DONE, then WAIT_ACK.
  - 0xFA at that final WAIT_ACK goes to READY and raises init_done.
- Init timeouts: INIT_WAIT_ACK uses ACK_TIMEOUT_CYC; BAT and ID each use BAT_TIMEOUT_CYC.
- Init responses:
  - 0xFE in any init WAIT_ACK triggers a resend (see Optional Feature).
  - Any other unexpected byte sets err_code=2 and enters ERROR.
- READY:
  - cmd_rdy=1. On cmd_vld&&cmd_rdy, latch cmd_data, clear the retry counter and go to CMD_SEND.
  - rx_vld in READY produces pkt_vld/pkt_data on the next cycle.
  - If cmd_vld and rx_vld arrive together, both are honoured: the byte is forwarded and the command is accepted.
- CMD_WAIT_ACK:
  - 0xFA produces rsp_vld=1, rsp_ok=1 and returns to READY.
  - 0xFE takes the resend path.
  - Other bytes are forwarded as pkt and the wait continues.
  - Timeout takes the resend path.
- cmd_rdy is 0 in every state except READY.
- In the SEND and WAIT_DONE states, rx_vld is ignored because the device is inhibited.
- ERROR: terminal. cmd_rdy=0 and init_done=0. Exit only via rst_n.
- If the error occurred during a command, emit rsp_vld=1, rsp_ok=0 once on entry to ERROR.
- Retry counter width is $clog2(MAX_RETRY+1). The timer is 32-bit and compares against parameter-1.

Optional Feature:
- Macro: PS2_CMD_RETRY_EN.
- Defined: 0xFE or an ACK timeout increments the retry counter and re-enters the corresponding *_SEND with the same byte. Once the counter equals MAX_RETRY, the next failure sets err_code=3 and enters ERROR.
- Undefined: 0xFE sets err_code=2 and an ACK timeout sets err_code=1, both entering ERROR immediately. The retry counter logic is absent.

Decomposition:
- Package ps2_pkg holds:
  - state enum (INIT_SEND, INIT_WAIT_DONE, INIT_WAIT_ACK, INIT_WAIT_BAT, INIT_WAIT_ID, INIT_EN_SEND, INIT_EN_WAIT_DONE, INIT_EN_WAIT_ACK, READY, CMD_SEND, CMD_WAIT_DONE, CMD_WAIT_ACK, ERROR);
  - byte constants PS2_CMD_RESET=0xFF, PS2_CMD_ENABLE=0xF4, PS2_RSP_ACK=0xFA, PS2_RSP_RESEND=0xFE, PS2_RSP_BAT_OK=0xAA;
  - err_code constants.
- One sub-module, ps2_timeout_cnt: loadable limit, clear, expired flag. It is reused for the ACK and BAT waits.

Test Plan:
- Device model ACKs 0xFF with 0xFA, sends 0xAA and 0x00, ACKs 0xF4 with 0xFA. Expect exactly two tx_wr_en pulses (0xFF then 0xF4), then init_done=1 and cmd_rdy=1, with err=0.
- After init, send host command 0xE8 and reply 0xFA. Expect one tx_wr_en with data 0xE8, then rsp_vld=1 and rsp_ok=1, then back in READY.
- Command 0xF3 answered with 0xFE twice, then 0xFA, with RETRY_EN. Expect three tx pulses with 0xF3 and rsp_ok=1. Without RETRY_EN: err_code=2 and rsp_ok=0 after the first 0xFE.
- Device silent after 0xFF, with ACK_TIMEOUT_CYC=100. With RETRY_EN, err_code=3 after 4 total sends. Without it, err_code=1 after about 100 cycles.
- In READY, rx_vld with 0x08 on the same cycle as cmd_vld with 0xF4. Expect pkt_vld with 0x08 and the command accepted (cmd_rdy drops the next cycle).
- rst_n asserted during CMD_WAIT_ACK. Expect all outputs 0 and the init sequence restarting with 0xFF.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 command controller states, protocol bytes and error codes
package ps2_pkg;

  typedef enum logic [3:0] {
    INIT_SEND,
    INIT_WAIT_DONE,
    INIT_WAIT_ACK,
    INIT_WAIT_BAT,
    INIT_WAIT_ID,
    INIT_EN_SEND,
    INIT_EN_WAIT_DONE,
    INIT_EN_WAIT_ACK,
    READY,
    CMD_SEND,
    CMD_WAIT_DONE,
    CMD_WAIT_ACK,
    ERROR
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BAD_RSP = 2'd2;
  localparam logic [1:0] ERR_RETRY   = 2'd3;

  function automatic logic is_cmd_state(state_t s);
    return (s == CMD_SEND) || (s == CMD_WAIT_DONE) || (s == CMD_WAIT_ACK);
  endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// rtl/ps2_timeout_cnt.sv - 32-bit wait timer with clear and loadable limit
module ps2_timeout_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 32'd1;
    end
  end

  // The count is stale during the clear cycle, so it cannot expire then.
  assign expired = !clr && (cnt >= limit - 32'd1);

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// rtl/ps2_cmd_ctrl.sv - PS/2 device init and host command sequencer with ACK/RESEND checking
// Define PS2_CMD_RETRY_EN to resend on RESEND or ACK timeout (up to MAX_RETRY) instead of failing.
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYC = 1_000_000,
  parameter int BAT_TIMEOUT_CYC = 25_000_000,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  output logic       tx_wr_en,
  output logic [7:0] tx_wr_data,
  input  logic       tx_wr_done,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic       cmd_vld,
  input  logic [7:0] cmd_data,
  output logic       cmd_rdy,
  output logic       rsp_vld,
  output logic       rsp_ok,
  output logic       pkt_vld,
  output logic [7:0] pkt_data,
  output logic       init_done,
  output logic       err,
  output logic [1:0] err_code
);

  state_t      state, state_prev;
  logic [7:0]  byte_q;
  logic [31:0] limit;
  logic        tmr_clr, expired, nack, go_err;
  logic [1:0]  go_code;

  assign tmr_clr = (state != state_prev);
  assign limit   = (state == INIT_WAIT_BAT || state == INIT_WAIT_ID) ?
                   32'(BAT_TIMEOUT_CYC) : 32'(ACK_TIMEOUT_CYC);
  assign nack    = (rx_vld && rx_data == PS2_RSP_RESEND) || (!rx_vld && expired);

  ps2_timeout_cnt u_tmr (
    .clk     (clk_sys),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .limit   (limit),
    .expired (expired)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_prev <= INIT_SEND;
    else        state_prev <= state;
  end

`ifdef PS2_CMD_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  logic [RW-1:0] retry_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if ((state == READY && cmd_vld) || state == INIT_WAIT_ID) begin
      retry_cnt <= '0;
    end else if (!go_err && nack && (state == INIT_WAIT_ACK || state == INIT_EN_WAIT_ACK ||
                                     state == CMD_WAIT_ACK)) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    go_err  = 1'b0;
    go_code = ERR_NONE;
    case (state)
      INIT_WAIT_DONE, INIT_EN_WAIT_DONE, CMD_WAIT_DONE:
        if (!tx_wr_done && expired) begin
          go_err  = 1'b1;
          go_code = ERR_TIMEOUT;
        end
      INIT_WAIT_BAT:
        if (rx_vld ? (rx_data != PS2_RSP_BAT_OK) : expired) begin
          go_err  = 1'b1;
          go_code = rx_vld ? ERR_BAD_RSP : ERR_TIMEOUT;
        end
      INIT_WAIT_ID:
        if (!rx_vld && expired) begin
          go_err  = 1'b1;
          go_code = ERR_TIMEOUT;
        end
      INIT_WAIT_ACK, INIT_EN_WAIT_ACK, CMD_WAIT_ACK:
        if (rx_vld && state != CMD_WAIT_ACK &&
            rx_data != PS2_RSP_ACK && rx_data != PS2_RSP_RESEND) begin
          go_err  = 1'b1;
          go_code = ERR_BAD_RSP;
        end else if (nack) begin
`ifdef PS2_CMD_RETRY_EN
          if (retry_cnt == RETRY_LIMIT) begin
            go_err  = 1'b1;
            go_code = ERR_RETRY;
          end
`else
          go_err  = 1'b1;
          go_code = rx_vld ? ERR_BAD_RSP : ERR_TIMEOUT;
`endif
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_SEND;
      byte_q     <= PS2_CMD_RESET;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= 8'h00;
      cmd_rdy    <= 1'b0;
      rsp_vld    <= 1'b0;
      rsp_ok     <= 1'b0;
      pkt_vld    <= 1'b0;
      pkt_data   <= 8'h00;
      init_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      tx_wr_en <= 1'b0;
      rsp_vld  <= 1'b0;
      pkt_vld  <= 1'b0;
      if (go_err) begin
        state     <= ERROR;
        err       <= 1'b1;
        err_code  <= go_code;
        cmd_rdy   <= 1'b0;
        init_done <= 1'b0;
        if (is_cmd_state(state)) begin
          rsp_vld <= 1'b1;
          rsp_ok  <= 1'b0;
        end
      end else begin
        case (state)
          INIT_SEND, INIT_EN_SEND, CMD_SEND: begin
            tx_wr_en   <= 1'b1;
            tx_wr_data <= byte_q;
            case (state)
              INIT_SEND:    state <= INIT_WAIT_DONE;
              INIT_EN_SEND: state <= INIT_EN_WAIT_DONE;
              default:      state <= CMD_WAIT_DONE;
            endcase
          end
          INIT_WAIT_DONE:    if (tx_wr_done) state <= INIT_WAIT_ACK;
          INIT_EN_WAIT_DONE: if (tx_wr_done) state <= INIT_EN_WAIT_ACK;
          CMD_WAIT_DONE:     if (tx_wr_done) state <= CMD_WAIT_ACK;
          INIT_WAIT_BAT:     if (rx_vld) state <= INIT_WAIT_ID;
          INIT_WAIT_ID:
            if (rx_vld) begin
              state  <= INIT_EN_SEND;
              byte_q <= PS2_CMD_ENABLE;
            end
          INIT_WAIT_ACK, INIT_EN_WAIT_ACK, CMD_WAIT_ACK:
            if (rx_vld && rx_data == PS2_RSP_ACK) begin
              if (state == INIT_WAIT_ACK) begin
                state <= INIT_WAIT_BAT;
              end else begin
                state     <= READY;
                init_done <= 1'b1;
                cmd_rdy   <= 1'b1;
                if (state == CMD_WAIT_ACK) begin
                  rsp_vld <= 1'b1;
                  rsp_ok  <= 1'b1;
                end
              end
            end else if (nack) begin
              // Only reachable with retries enabled; resend the same byte.
              case (state)
                INIT_WAIT_ACK:    state <= INIT_SEND;
                INIT_EN_WAIT_ACK: state <= INIT_EN_SEND;
                default:          state <= CMD_SEND;
              endcase
            end else if (rx_vld) begin
              pkt_vld  <= 1'b1;
              pkt_data <= rx_data;
            end
          READY: begin
            if (rx_vld) begin
              pkt_vld  <= 1'b1;
              pkt_data <= rx_data;
            end
            if (cmd_vld && cmd_rdy) begin
              byte_q  <= cmd_data;
              cmd_rdy <= 1'b0;
              state   <= CMD_SEND;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
